// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO feeding an external ALU through an IDLE/ISSUE/CAPTURE/RESP sequencer
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [2:0]               cmd_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_opt,
  output logic                     alu_load,
  input  logic [WIDTH-1:0]         alu_dout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [2:0]               res_op,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 + 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t         state_q, state_d;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;

  logic [2:0]       hold_op_q;
  logic [WIDTH-1:0] hold_a_q, hold_b_q;

  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [2:0]       res_op_q;

  logic           push, pop, capture, release_res;
  logic [EW-1:0]  head;

  // cmd_ready depends only on registered occupancy, so no input reaches it combinationally
  assign cmd_ready  = (count_q < CW'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign head       = mem_q[rd_ptr_q];

  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE);
  assign alu_a      = hold_a_q;
  assign alu_b      = hold_b_q;
  assign alu_opt    = hold_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;

  // Next-state and strobe decode for the sequencer
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    alu_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_load = 1'b1;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) begin
          release_res = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FIFO storage; entries are {op, a, b}, contents need no reset since count gates them
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  // FIFO pointers wrap naturally at DEPTH (power of two); push+pop keeps the count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Hold registers keep the ALU inputs steady from ISSUE through CAPTURE
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_op_q <= '0;
      hold_a_q  <= '0;
      hold_b_q  <= '0;
    end else if (pop) begin
      hold_op_q <= head[EW-1 -: 3];
      hold_a_q  <= head[2*WIDTH-1 -: WIDTH];
      hold_b_q  <= head[WIDTH-1:0];
    end
  end

  // Result register: loaded in CAPTURE, held through RESP until downstream takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= alu_dout;
      res_op_q    <= hold_op_q;
    end else if (release_res) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule
